mod_pmersenne_reduce_hs: RTL and testbench

- Generic pipelined modular reducer for pseudo-Mersenne primes P = 2^N − K; reduces a 2N-bit operand, typically a multiplier product, to [0, P).
- Generalises our secp256k1 reducer: width N and constant K are parameters, a per-transaction tag rides alongside the data, full valid/ready backpressure, flush and in-flight occupancy count.
- Sits between the wide multiplier and the field-arithmetic sequencer.

---
 rtl/mod_pmersenne_reduce_hs.sv | 145 ++++++++++++++
 tb/tb_mod_pmersenne_reduce_hs.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_pmersenne_reduce_hs.sv
// Pipelined reducer of a 2N-bit operand modulo P = 2^N - K with tag sideband, valid/ready and flush.
// Define MOD_PM_LAZY_EN to drop the final subtraction: result < 2^N, congruent mod P, latency 3.
module mod_pmersenne_reduce_hs #(
  parameter int           N  = 256,
  parameter logic [N-1:0] K  = 256'h1000003D1,
  parameter int           KW = 33,
  parameter int           TW = 8
) (
  input  logic           clk,
  input  logic           areset,
  input  logic           flush,
  input  logic           ival,
  output logic           irdy,
  input  logic [2*N-1:0] a,
  input  logic [TW-1:0]  itag,
  output logic           oval,
  input  logic           ordy,
  output logic [N-1:0]   c,
  output logic [TW-1:0]  otag,
  output logic [2:0]     count
);

  if (KW > N/2 - 1) begin : g_kw_check
    $error("mod_pmersenne_reduce_hs: KW must not exceed N/2-1");
  end

  localparam int            W1 = N + KW + 1;
  localparam logic [KW-1:0] KK = K[KW-1:0];
  localparam logic [N-1:0]  KN = {{(N-KW){1'b0}}, KK};
  localparam logic [N-1:0]  P  = ~KN + {{(N-1){1'b0}}, 1'b1};

  logic           v1_q, v2_q, v3_q;
  logic           rdy1, rdy2, rdy3;
  logic           en1, ld1, ld2, ld3;
  logic           acc, pop;
  logic [2:0]     count_q, count_d;

  logic [N+KW-1:0] prod1;
  logic [W1-1:0]   r1_d, r1_q;
  logic [KW:0]     h2;
  logic [N:0]      prod2, r2_d, r2_q;
  logic [N-1:0]    r3_d, r3_q;
  logic [TW-1:0]   t1_q, t2_q, t3_q;

  // Fold the upper half once: H*2^N == H*K (mod P).
  assign prod1 = {{KW{1'b0}}, a[2*N-1:N]} * {{N{1'b0}}, KK};
  assign r1_d  = {1'b0, prod1} + {{(KW+1){1'b0}}, a[N-1:0]};

  // Second fold; H2 is at most KW+1 bits so the product fits well inside N+1 bits.
  assign h2    = r1_q[W1-1:N];
  assign prod2 = {{(N-KW){1'b0}}, h2} * {1'b0, KN};
  assign r2_d  = prod2 + {1'b0, r1_q[N-1:0]};

  assign r3_d  = r2_q[N-1:0] + (r2_q[N] ? KN : '0);

`ifdef MOD_PM_LAZY_EN
  assign rdy3 = ordy;
  assign oval = v3_q;
  assign c    = r3_q;
  assign otag = t3_q;
`else
  logic          v4_q, rdy4, ld4;
  logic [N-1:0]  r4_d, r4_q;
  logic [TW-1:0] t4_q;

  assign r4_d = (r3_q >= P) ? r3_q - P : r3_q;
  assign rdy4 = ordy;
  assign rdy3 = ~v4_q | rdy4;
  assign ld4  = v3_q & rdy3;
  assign oval = v4_q;
  assign c    = r4_q;
  assign otag = t4_q;
`endif

  assign rdy2  = ~v3_q | rdy3;
  assign rdy1  = ~v2_q | rdy2;
  assign en1   = ~v1_q | rdy1;
  assign irdy  = en1 & ~flush;
  assign acc   = ival & irdy;
  assign pop   = oval & ordy;
  assign ld1   = ival & en1;
  assign ld2   = v1_q & rdy1;
  assign ld3   = v2_q & rdy2;
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (acc && !pop) begin
      count_d = count_q + 3'd1;
    end else if (!acc && pop) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
`ifndef MOD_PM_LAZY_EN
      v4_q    <= 1'b0;
`endif
      count_q <= 3'd0;
    end else if (flush) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
`ifndef MOD_PM_LAZY_EN
      v4_q    <= 1'b0;
`endif
      count_q <= 3'd0;
    end else begin
      // An enabled stage takes whatever its upstream holds, so bubbles collapse.
      if (en1)  v1_q <= ival;
      if (rdy1) v2_q <= v1_q;
      if (rdy2) v3_q <= v2_q;
`ifndef MOD_PM_LAZY_EN
      if (rdy3) v4_q <= v3_q;
`endif
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld1) begin
      r1_q <= r1_d;
      t1_q <= itag;
    end
    if (ld2) begin
      r2_q <= r2_d;
      t2_q <= t1_q;
    end
    if (ld3) begin
      r3_q <= r3_d;
      t3_q <= t2_q;
    end
`ifndef MOD_PM_LAZY_EN
    if (ld4) begin
      r4_q <= r4_d;
      t4_q <= t3_q;
    end
`endif
  end

endmodule

// File: tb/tb_mod_pmersenne_reduce_hs.sv
// Bench for mod_pmersenne_reduce_hs at default parameters (secp256k1 field); honours MOD_PM_LAZY_EN.
module tb_mod_pmersenne_reduce_hs;

  localparam logic [255:0] P_TB =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] K_TB = 256'h1_000003D1;
`ifdef MOD_PM_LAZY_EN
  localparam int LAT  = 2;
  localparam int MAXC = 3;
`else
  localparam int LAT  = 3;
  localparam int MAXC = 4;
`endif

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic         flush = 1'b0;
  logic         ival = 1'b0;
  logic         irdy;
  logic [511:0] a = '0;
  logic [7:0]   itag = '0;
  logic         oval;
  logic         ordy = 1'b1;
  logic [255:0] c;
  logic [7:0]   otag;
  logic [2:0]   count;

  int n_chk = 0;
  int n_fail = 0;

  mod_pmersenne_reduce_hs dut (
    .clk(clk), .areset(areset), .flush(flush), .ival(ival), .irdy(irdy),
    .a(a), .itag(itag), .oval(oval), .ordy(ordy), .c(c), .otag(otag), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain wide modulo.
  function automatic logic [255:0] ref_mod(input logic [511:0] x);
    logic [511:0] r;
    r = x % {256'b0, P_TB};
    return r[255:0];
  endfunction

  function automatic logic [511:0] bp_a(input int i);
    return {16{32'h9E3779B9 ^ i}};
  endfunction

  typedef struct packed {
    logic [255:0] c;
    logic [7:0]   tag;
  } exp_t;
  exp_t q[$];

  logic         have_prev = 1'b0;
  logic         p_oval, p_ordy, p_flush;
  logic [255:0] p_c;
  logic [7:0]   p_tag;

  always @(negedge clk) begin
    exp_t e;
    if (areset) begin
      q.delete();
      have_prev = 1'b0;
    end else begin
      chk("count", 512'(count), 512'(q.size()));
      if (flush) chk("irdy_flush", 512'(irdy), 512'(0));
      if (!ordy && q.size() == MAXC) chk("irdy_full", 512'(irdy), 512'(0));
      if (have_prev && p_oval && !p_ordy && !p_flush) begin
        chk("hold_oval", 512'(oval), 512'(1));
        chk("hold_c", 512'(c), 512'(p_c));
        chk("hold_tag", 512'(otag), 512'(p_tag));
      end
      if (flush) begin
        q.delete();
      end else begin
        if (oval && ordy) begin
          chk("out_pending", 512'(q.size() != 0), 512'(1));
          if (q.size() != 0) begin
            e = q.pop_front();
`ifdef MOD_PM_LAZY_EN
            chk("c_congruent", 512'(ref_mod({256'b0, c})), 512'(e.c));
`else
            chk("c", 512'(c), 512'(e.c));
`endif
            chk("otag", 512'(otag), 512'(e.tag));
          end
        end
        if (ival && irdy) begin
          e.c = ref_mod(a);
          e.tag = itag;
          q.push_back(e);
        end
      end
      have_prev = 1'b1;
      p_oval = oval;
      p_ordy = ordy;
      p_flush = flush;
      p_c = c;
      p_tag = otag;
    end
  end

  task automatic send(input logic [511:0] av, input logic [7:0] tg);
    logic ok;
    ok = 1'b0;
    ival = 1'b1;
    a = av;
    itag = tg;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (irdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("irdy_timeout", 512'(irdy), 512'(1));
    @(posedge clk);
    #1;
    ival = 1'b0;
  endtask

  // Accept one operand into an empty pipe, then pin latency and result.
  task automatic run_one(input logic [511:0] av, input logic [7:0] tg, input logic [255:0] exp_c);
    send(av, tg);
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk);
      #1;
      if (i < LAT) begin
        chk("lat_early", 512'(oval), 512'(0));
      end else begin
        chk("lat_oval", 512'(oval), 512'(1));
        chk("lit_c", 512'(c), 512'(exp_c));
        chk("lit_tag", 512'(otag), 512'(tg));
      end
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (count == 3'd0 && !oval) break;
    end
    chk("drain_count", 512'(count), 512'(0));
    chk("drain_oval", 512'(oval), 512'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] pm1sq;
    pm1sq = {256'b0, P_TB - 256'd1} * {256'b0, P_TB - 256'd1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_oval", 512'(oval), 512'(0));
    chk("rst_count", 512'(count), 512'(0));
    chk("rst_irdy", 512'(irdy), 512'(1));
    areset = 1'b0;
    @(posedge clk);
    #1;

    run_one(512'd0, 8'd1, 256'd0);
`ifdef MOD_PM_LAZY_EN
    run_one({256'b0, P_TB}, 8'd2, P_TB);
    run_one({255'b0, 1'b1, 256'b0}, 8'd3, K_TB);
`else
    run_one({256'b0, P_TB}, 8'd2, 256'd0);
    run_one({255'b0, 1'b1, 256'b0}, 8'd3, K_TB);
    run_one(pm1sq, 8'd4, 256'd1);
    run_one({512{1'b1}}, 8'd5, 256'h1_000007A2_000E90A0);
`endif
    wait_empty();

    // Backpressure: fill while the sink stalls, then release.
    @(posedge clk);
    #1;
    ordy = 1'b0;
    for (int i = 0; i < MAXC; i++) send(bp_a(i), 8'(i));
    ival = 1'b1;
    a = bp_a(MAXC);
    itag = 8'(MAXC);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_irdy", 512'(irdy), 512'(0));
      chk("bp_count", 512'(count), 512'(MAXC));
    end
    @(posedge clk);
    #1;
    ordy = 1'b1;
    for (int i = MAXC; i < 6; i++) send(bp_a(i), 8'(i));
    wait_empty();

    // Flush with three in flight and a new offer in the same cycle.
    @(posedge clk);
    #1;
    ordy = 1'b0;
    for (int i = 0; i < 3; i++) send(bp_a(20 + i), 8'(8'h40 + i));
    flush = 1'b1;
    ival = 1'b1;
    a = bp_a(9);
    itag = 8'hEE;
    @(negedge clk);
    chk("flush_irdy", 512'(irdy), 512'(0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    ival = 1'b0;
    chk("flush_count", 512'(count), 512'(0));
    chk("flush_oval", 512'(oval), 512'(0));
    ordy = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("flush_quiet", 512'(count), 512'(0));

    // Asynchronous reset with three in flight.
    for (int i = 0; i < 3; i++) send(bp_a(30 + i), 8'(8'h50 + i));
    #1;
    areset = 1'b1;
    #1;
    chk("arst_oval", 512'(oval), 512'(0));
    chk("arst_count", 512'(count), 512'(0));
    @(negedge clk);
    @(posedge clk);
    #1;
    areset = 1'b0;
    run_one({255'b0, 1'b1, 256'b0}, 8'h77, K_TB);
    wait_empty();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
